arbiter_iwrr_prog: RTL and testbench

- Parametrised interleaved weighted round-robin (IWRR) arbiter with runtime-programmable per-requester weights.
- Adds a plain round-robin mode, a grant index output, back-to-back grants, and a round-completion pulse.
- Sits in front of shared resources (bus ports, memory banks, DMA channels).
- Each grant is held until the consumer accepts it with grant_ready.

---
 rtl/arbiter_iwrr_prog.sv | 159 +++++++++++++++
 tb/tb_arbiter_iwrr_prog.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_iwrr_prog.sv
// ---------------------------------------------------------------------------
// arbiter_iwrr_prog
//   Interleaved weighted round-robin arbiter with runtime-programmable
//   weights, a plain round-robin mode, a binary grant index, back-to-back
//   grants and a round-completion pulse.
//
// Ports
//   clk          : clock, all state updates on the rising edge
//   rst_n        : asynchronous active-low reset
//   request      : per-requester request level
//   weight_cfg   : packed weights, requester i uses [i*P_WEIGHT_W +: P_WEIGHT_W]
//   weight_load  : one-cycle strobe capturing weight_cfg into the pending set
//   mode         : 0 = IWRR (credit based), 1 = plain round-robin
//   grant_ready  : consumer accepts the current grant
//   grant_valid  : registered one-hot grant, all zero when idle
//   grant_idx    : binary index of the granted requester, 0 when idle
//   round_done   : registered one-cycle pulse following each credit reload
//
// Handshake: a grant is offered on grant_valid/grant_idx and held stable until
// the cycle in which grant_ready is high; that edge retires it and may present
// the next grant at once. grant_ready has no effect while grant_valid is zero.
// ---------------------------------------------------------------------------
module arbiter_iwrr_prog #(
   parameter int P_REQUESTER_NUM = 4,
   parameter int P_WEIGHT_W      = 4,
   parameter int P_RESET_WEIGHT  = 1,
   localparam int IDX_W = (P_REQUESTER_NUM > 2) ? $clog2(P_REQUESTER_NUM) : 1
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [P_REQUESTER_NUM-1:0]            request,
   input  logic [P_REQUESTER_NUM*P_WEIGHT_W-1:0] weight_cfg,
   input  logic                                  weight_load,
   input  logic                                  mode,
   input  logic                                  grant_ready,
   output logic [P_REQUESTER_NUM-1:0]            grant_valid,
   output logic [IDX_W-1:0]                      grant_idx,
   output logic                                  round_done
);

   typedef logic [P_REQUESTER_NUM-1:0][P_WEIGHT_W-1:0] wvec_t;

   localparam logic [P_WEIGHT_W-1:0] RST_W = P_WEIGHT_W'(P_RESET_WEIGHT);

   wvec_t                      credit_q, credit_d;
   wvec_t                      weight_q, weight_d;
   wvec_t                      pend_q, pend_d;
   logic                       pend_flag_q, pend_flag_d;
   logic [IDX_W-1:0]           ptr_q, ptr_d;
   logic [P_REQUESTER_NUM-1:0] gnt_q, gnt_d;
   logic [IDX_W-1:0]           gidx_q, gidx_d;
   logic                       round_done_q, round_done_d;

   // combinational intermediates
   logic                       free_w, accept_w, reload_w, rr_apply_w, apply_w;
   wvec_t                      credit_acc, credit_nx, weight_nx;
   logic [P_REQUESTER_NUM-1:0] weight_nz, has_credit, eligible;
   logic [IDX_W-1:0]           ptr_acc, scan_start, sel;
   logic                       found;
   int                         j;

   always_comb begin
      free_w   = (gnt_q == '0) || grant_ready;
      accept_w = (gnt_q != '0) && grant_ready;

      // Retire the accepted grant: spend one credit (IWRR only) and move the
      // pointer just past the winner.
      credit_acc = credit_q;
      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         if (accept_w && gnt_q[i] && !mode && credit_q[i] != '0)
            credit_acc[i] = credit_q[i] - 1'b1;
      end
      if (accept_w)
         ptr_acc = (gidx_q == IDX_W'(P_REQUESTER_NUM - 1)) ? '0 : gidx_q + 1'b1;
      else
         ptr_acc = ptr_q;

      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         weight_nz[i]  = (weight_q[i] != '0);
         has_credit[i] = (credit_acc[i] != '0);
      end

      // A reload happens only when someone with a non-zero weight is asking
      // and every requester that asks has run out of credit. Requesters whose
      // weight is zero can never trigger it.
      reload_w   = free_w && !mode && ((request & weight_nz) != '0)
                   && ((request & has_credit) == '0);
      // In round-robin mode there are no rounds, so pending weights take
      // effect as soon as the arbiter is free.
      rr_apply_w = free_w && mode && pend_flag_q;
      apply_w    = (reload_w || rr_apply_w) && pend_flag_q;

      weight_nx = apply_w ? pend_q : weight_q;
      credit_nx = (reload_w || rr_apply_w) ? weight_nx : credit_acc;

      for (int i = 0; i < P_REQUESTER_NUM; i++) begin
         eligible[i] = request[i] && (mode ? (weight_nx[i] != '0) : (credit_nx[i] != '0));
      end

      // A freshly reloaded round restarts the scan from requester 0.
      scan_start = reload_w ? '0 : ptr_acc;
      found      = 1'b0;
      sel        = '0;
      j          = 0;
      for (int k = 0; k < P_REQUESTER_NUM; k++) begin
         j = int'(scan_start) + k;
         if (j >= P_REQUESTER_NUM) j = j - P_REQUESTER_NUM;
         if (!found && eligible[j]) begin
            found = 1'b1;
            sel   = IDX_W'(j);
         end
      end

      // Outstanding grants hold; a free arbiter presents the new selection.
      gnt_d  = gnt_q;
      gidx_d = gidx_q;
      if (free_w) begin
         for (int i = 0; i < P_REQUESTER_NUM; i++)
            gnt_d[i] = found && (sel == IDX_W'(i));
         gidx_d = found ? sel : '0;
      end

      credit_d     = credit_nx;
      weight_d     = weight_nx;
      ptr_d        = ptr_acc;
      round_done_d = reload_w;

      // A load in the same cycle as an apply leaves the new set pending.
      pend_d      = weight_load ? wvec_t'(weight_cfg) : pend_q;
      pend_flag_d = weight_load ? 1'b1 : (apply_w ? 1'b0 : pend_flag_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         credit_q     <= {P_REQUESTER_NUM{RST_W}};
         weight_q     <= {P_REQUESTER_NUM{RST_W}};
         pend_q       <= {P_REQUESTER_NUM{RST_W}};
         pend_flag_q  <= 1'b0;
         ptr_q        <= '0;
         gnt_q        <= '0;
         gidx_q       <= '0;
         round_done_q <= 1'b0;
      end else begin
         credit_q     <= credit_d;
         weight_q     <= weight_d;
         pend_q       <= pend_d;
         pend_flag_q  <= pend_flag_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         gidx_q       <= gidx_d;
         round_done_q <= round_done_d;
      end
   end

   assign grant_valid = gnt_q;
   assign grant_idx   = gidx_q;
   assign round_done  = round_done_q;

endmodule

// File: tb/tb_arbiter_iwrr_prog.sv
// Directed bench for arbiter_iwrr_prog (3 requesters, 4-bit weights).
// Inputs change 1ns after the rising edge; the monitor samples on the falling
// edge, so a grant it sees with grant_ready high retires on the next rising
// edge.
module tb_arbiter_iwrr_prog;

   localparam int N     = 3;
   localparam int W     = 4;
   localparam int IDX_W = 2;

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     request;
   logic [N*W-1:0]   weight_cfg;
   logic             weight_load;
   logic             mode;
   logic             grant_ready;
   logic [N-1:0]     grant_valid;
   logic [IDX_W-1:0] grant_idx;
   logic             round_done;

   arbiter_iwrr_prog #(
      .P_REQUESTER_NUM(N),
      .P_WEIGHT_W     (W),
      .P_RESET_WEIGHT (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .request    (request),
      .weight_cfg (weight_cfg),
      .weight_load(weight_load),
      .mode       (mode),
      .grant_ready(grant_ready),
      .grant_valid(grant_valid),
      .grant_idx  (grant_idx),
      .round_done (round_done)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   int n_acc  = 0;
   int rd_log[$];
   logic [IDX_W-1:0] exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int rd_at(input int i);
      return (rd_log.size() > i) ? rd_log[i] : -1;
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_n) begin
         if (round_done) rd_log.push_back(n_acc);
         if ((grant_valid != '0) && grant_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++;
               $display("FAIL unexpected_grant: got idx %0d valid %b, none expected",
                        grant_idx, grant_valid);
            end else begin
               logic [IDX_W-1:0] e;
               logic [N-1:0]     oh;
               e  = exp_q.pop_front();
               oh = '0;
               oh[e] = 1'b1;
               if (grant_idx !== e || grant_valid !== oh) begin
                  n_miss++;
                  $display("FAIL grant_%0d: got idx %0d valid %b expected idx %0d valid %b",
                           n_acc, grant_idx, grant_valid, e, oh);
               end
            end
            n_acc++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      request     = '0;
      weight_cfg  = '0;
      weight_load = 1'b0;
      mode        = 1'b0;
      grant_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_acc = 0;
      rd_log.delete();
   endtask

   // Program weights while in round-robin mode so they take effect at once.
   task automatic program_rr(input logic [N*W-1:0] cfg);
      mode        = 1'b1;
      weight_cfg  = cfg;
      weight_load = 1'b1;
      cycle();
      weight_load = 1'b0;
      cycle();
      cycle();
   endtask

   task automatic wait_acc(input int target, input int budget);
      int k;
      k = 0;
      while (n_acc < target && k < budget) begin
         cycle();
         k++;
      end
      if (n_acc < target) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_acc: got %0d accepts expected %0d", n_acc, target);
      end
   endtask

   task automatic push_seq(input int s[$]);
      foreach (s[i]) exp_q.push_back(IDX_W'(s[i]));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r1[$];
      int r2[$];
      r1 = '{0, 1, 2, 0, 1, 2, 0, 1, 0, 0};
      r2 = '{0, 1, 2, 2, 2, 2};

      // 1) reset values, weights {5,3,2}, two full IWRR rounds
      do_reset();
      check("rst_grant_valid", int'(grant_valid), 0);
      check("rst_grant_idx", int'(grant_idx), 0);
      check("rst_round_done", int'(round_done), 0);
      program_rr(12'h235);
      mode = 1'b0;
      push_seq(r1);
      push_seq(r1);
      request     = 3'b111;
      grant_ready = 1'b1;
      wait_acc(20, 200);
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s1_rd_count", rd_log.size(), 2);
      check("s1_rd_first", rd_at(0), 10);
      check("s1_rd_second", rd_at(1), 20);
      check("s1_queue_empty", exp_q.size(), 0);

      // 2) grant to requester 1 held for 4 cycles while request/mode move
      do_reset();
      program_rr(12'h235);
      mode = 1'b0;
      push_seq('{0, 1, 2});
      request = 3'b111;
      cycle();
      check("s2_first_grant", int'(grant_valid), 3'b001);
      grant_ready = 1'b1;
      cycle();
      grant_ready = 1'b0;
      request     = 3'b101;
      check("s2_grant1", int'(grant_valid), 3'b010);
      for (int k = 0; k < 4; k++) begin
         mode = (k == 1 || k == 2);
         cycle();
         check("s2_hold_valid", int'(grant_valid), 3'b010);
         check("s2_hold_idx", int'(grant_idx), 1);
      end
      mode        = 1'b0;
      grant_ready = 1'b1;
      cycle();
      grant_ready = 1'b0;
      check("s2_next_idx", int'(grant_idx), 2);
      grant_ready = 1'b1;
      cycle();
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s2_accepts", n_acc, 3);
      check("s2_queue_empty", exp_q.size(), 0);

      // 3) reset weights, request 101: alternating grants, round every 2
      do_reset();
      push_seq('{0, 2, 0, 2});
      request     = 3'b101;
      grant_ready = 1'b1;
      cycle();
      check("s3_latency", int'(grant_valid), 3'b001);
      wait_acc(4, 50);
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s3_rd_count", rd_log.size(), 2);
      check("s3_rd_first", rd_at(0), 2);
      check("s3_rd_second", rd_at(1), 4);
      check("s3_queue_empty", exp_q.size(), 0);

      // 4) weights {1,1,4} loaded mid-round take effect at the next round
      do_reset();
      program_rr(12'h235);
      mode = 1'b0;
      push_seq(r1);
      push_seq(r2);
      request     = 3'b111;
      grant_ready = 1'b1;
      wait_acc(4, 50);
      weight_cfg  = 12'h411;
      weight_load = 1'b1;
      cycle();
      weight_load = 1'b0;
      wait_acc(16, 200);
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s4_rd_count", rd_log.size(), 2);
      check("s4_rd_first", rd_at(0), 10);
      check("s4_rd_second", rd_at(1), 16);
      check("s4_queue_empty", exp_q.size(), 0);

      // 5) weight 0 masks requester 0 in both modes
      do_reset();
      program_rr(12'h230);
      mode        = 1'b0;
      request     = 3'b001;
      grant_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("s5_no_grant", int'(grant_valid), 0);
         check("s5_no_round", int'(round_done), 0);
      end
      mode    = 1'b1;
      request = 3'b111;
      push_seq('{1, 2, 1, 2});
      wait_acc(4, 50);
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s5_rd_none", rd_log.size(), 0);
      check("s5_queue_empty", exp_q.size(), 0);

      // 6) asynchronous reset while a grant to requester 2 is outstanding
      do_reset();
      request = 3'b100;
      cycle();
      check("s6_grant2", int'(grant_valid), 3'b100);
      #2;
      rst_n = 1'b0;
      #1;
      check("s6_async_valid", int'(grant_valid), 0);
      check("s6_async_idx", int'(grant_idx), 0);
      cycle();
      rst_n = 1'b1;
      n_acc = 0;
      rd_log.delete();
      push_seq('{0, 1, 2});
      request     = 3'b111;
      grant_ready = 1'b1;
      wait_acc(3, 50);
      grant_ready = 1'b0;
      request     = '0;
      cycle();
      check("s6_rd_first", rd_at(0), 3);
      check("s6_queue_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
